// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request at a time, word-wide RAM ports,
// sub-word stores done as read-modify-write since the RAM has no byte enables.
module mem_lsu #(
   parameter int MEM_AW = 17,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   output logic [4:0]        resp_rd,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [MEM_AW-1:0] ram_waddr,
   output logic [31:0]       ram_wdata,
   output logic              ram_re,
   output logic [MEM_AW-1:0] ram_raddr,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_REQ,
      S_LD_DATA,
      S_RMW_RD,
      S_RMW_MRG,
      S_ST_WR,
      S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [4:0]         rd_q, rd_d;
   logic               err_q, err_d;
   // Holds the store word (SW), the merged word (SB/SH) or the extended load result.
   logic [31:0]        data_q, data_d;

   logic [MEM_AW-1:0]  word_addr;
   logic               unused_addr_hi;

   function automatic logic req_error(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
      logic bad_f3;
      logic mis;
      if (we) bad_f3 = (f3 > 3'b010);
      else    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      case (f3[1:0])
         2'b01:   mis = a[0];
         2'b10:   mis = |a;
         default: mis = 1'b0;
      endcase
      return bad_f3 | mis;
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      if (f3 == 3'b000) begin
         case (a)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end else if (a[1]) begin
         r[31:16] = wd[15:0];
      end else begin
         r[15:0] = wd[15:0];
      end
      return r;
   endfunction

   assign word_addr      = addr_q[MEM_AW+1:2];
   assign unused_addr_hi = ^addr_q[ADDR_W-1:MEM_AW+2];

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      err_d    = err_q;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rd_d     = req_rd;
               data_d   = req_wdata;
               err_d    = req_error(req_we, req_funct3, req_addr[1:0]);
               if (err_d)                      state_d = S_RESP;
               else if (!req_we)               state_d = S_LD_REQ;
               else if (req_funct3 == 3'b010)  state_d = S_ST_WR;
               else                            state_d = S_RMW_RD;
            end
         end
         S_LD_REQ:  state_d = S_LD_DATA;
         S_LD_DATA: begin
            data_d  = load_ext(funct3_q, addr_q[1:0], ram_rdata);
            state_d = S_RESP;
         end
         S_RMW_RD:  state_d = S_RMW_MRG;
         S_RMW_MRG: begin
            data_d  = merge(funct3_q, addr_q[1:0], ram_rdata, wdata_q);
            state_d = S_ST_WR;
         end
         S_ST_WR:   state_d = S_RESP;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs decode from registered state only, so an async reset drops them at once.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      ram_re     = (state_q == S_LD_REQ) || (state_q == S_RMW_RD);
      ram_we     = (state_q == S_ST_WR);
      ram_ce     = ram_re | ram_we;
      ram_raddr  = ram_re ? word_addr : '0;
      ram_waddr  = ram_we ? word_addr : '0;
      ram_wdata  = ram_we ? data_q : 32'd0;
      resp_valid = (state_q == S_RESP);
      resp_err   = resp_valid & err_q;
      resp_rd    = 5'd0;
      resp_rdata = 32'd0;
      if (resp_valid && !we_q && !err_q) begin
         resp_rd    = rd_q;
         resp_rdata = data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         rd_q     <= 5'd0;
         err_q    <= 1'b0;
         data_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         err_q    <= err_d;
         data_q   <= data_d;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural one-cycle-latency word RAM.
module tb_mem_lsu;

   localparam int MEM_AW = 17;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;
   logic              resp_valid;
   logic [4:0]        resp_rd;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              ram_ce;
   logic              ram_we;
   logic [MEM_AW-1:0] ram_waddr;
   logic [31:0]       ram_wdata;
   logic              ram_re;
   logic [MEM_AW-1:0] ram_raddr;
   logic [31:0]       ram_rdata;

   logic [31:0] mem [0:(1<<MEM_AW)-1];
   int checks = 0;
   int errors = 0;

   mem_lsu #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   always @(negedge clk) begin
      if (ram_re && ram_we) begin
         errors++;
         $error("FAIL re_we_overlap: observed re=1 we=1 required not both");
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request in IDLE; returns #1 into cycle C1.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0;
      req_wdata = 32'd0; req_rd = 5'd0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] waddr,
                          input logic [31:0] exp);
      issue(1'b0, f3, addr, 32'd0, rd);
      chk({tag, "_c1_re"}, ram_re, 1);
      chk({tag, "_c1_raddr"}, ram_raddr, waddr);
      chk({tag, "_c1_ready"}, req_ready, 0);
      step();
      chk({tag, "_c2_re"}, ram_re, 0);
      step();
      chk({tag, "_c3_valid"}, resp_valid, 1);
      chk({tag, "_c3_rd"}, resp_rd, rd);
      chk({tag, "_c3_rdata"}, resp_rdata, exp);
      chk({tag, "_c3_err"}, resp_err, 0);
      step();
      chk({tag, "_c4_ready"}, req_ready, 1);
      chk({tag, "_c4_valid"}, resp_valid, 0);
   endtask

   task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
      issue(we, f3, addr, 32'hFFFF_FFFF, 5'd7);
      chk({tag, "_valid"}, resp_valid, 1);
      chk({tag, "_err"}, resp_err, 1);
      chk({tag, "_rdata"}, resp_rdata, 0);
      chk({tag, "_rd"}, resp_rd, 0);
      chk({tag, "_ce"}, ram_ce, 0);
      step();
      chk({tag, "_ready"}, req_ready, 1);
      chk({tag, "_ce_after"}, ram_ce, 0);
      chk({tag, "_valid_after"}, resp_valid, 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'd0;
      mem[17'h40] = 32'h8899_AABB;
      ram_rdata = 32'd0;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0;
      req_wdata = 32'd0; req_rd = 5'd0;
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", resp_valid, 0);
      chk("rst_ce", ram_ce, 0);
      chk("rst_wdata", ram_wdata, 0);
      step();
      step();
      rst = 1'b0;
      step();

      do_load("lb",  3'b000, 32'h101, 5'd5, 32'h40, 32'hFFFF_FFAA);
      do_load("lhu", 3'b101, 32'h102, 5'd6, 32'h40, 32'h0000_8899);
      do_load("lh",  3'b001, 32'h102, 5'd7, 32'h40, 32'hFFFF_8899);
      do_load("lw",  3'b010, 32'h100, 5'd8, 32'h40, 32'h8899_AABB);

      // SB 0x103: read, merge, write, respond
      issue(1'b1, 3'b000, 32'h103, 32'h0000_0012, 5'd9);
      chk("sb_c1_re", ram_re, 1);
      chk("sb_c1_raddr", ram_raddr, 32'h40);
      chk("sb_c1_we", ram_we, 0);
      step();
      chk("sb_c2_ce", ram_ce, 0);
      step();
      chk("sb_c3_we", ram_we, 1);
      chk("sb_c3_waddr", ram_waddr, 32'h40);
      chk("sb_c3_wdata", ram_wdata, 32'h1299_AABB);
      chk("sb_c3_valid", resp_valid, 0);
      step();
      chk("sb_c4_valid", resp_valid, 1);
      chk("sb_c4_rd", resp_rd, 0);
      chk("sb_c4_err", resp_err, 0);
      step();
      do_load("lw_after_sb", 3'b010, 32'h100, 5'd10, 32'h40, 32'h1299_AABB);

      // SW 0x200
      issue(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 5'd11);
      chk("sw_c1_we", ram_we, 1);
      chk("sw_c1_re", ram_re, 0);
      chk("sw_c1_waddr", ram_waddr, 32'h80);
      chk("sw_c1_wdata", ram_wdata, 32'hDEAD_BEEF);
      step();
      chk("sw_c2_valid", resp_valid, 1);
      chk("sw_c2_rd", resp_rd, 0);
      step();
      do_load("lbu", 3'b100, 32'h203, 5'd12, 32'h80, 32'h0000_00DE);

      // Upper address bits ignored: wraps to word 0x40
      do_load("lw_wrap", 3'b010, 32'h8000_0100, 5'd13, 32'h40, 32'h1299_AABB);

      do_err("err_lw_mis",  1'b0, 3'b010, 32'h102);
      do_err("err_lh_mis",  1'b0, 3'b001, 32'h101);
      do_err("err_ld_f011", 1'b0, 3'b011, 32'h100);
      do_err("err_st_f011", 1'b1, 3'b011, 32'h100);
      chk("err_mem_intact", mem[17'h40], 32'h1299_AABB);

      // SH 0x100 with reset during RMW_MRG
      issue(1'b1, 3'b001, 32'h100, 32'h0000_5555, 5'd14);
      chk("rmw_rst_c1_re", ram_re, 1);
      step();
      rst = 1'b1;
      #1;
      chk("rmw_rst_we", ram_we, 0);
      chk("rmw_rst_re", ram_re, 0);
      chk("rmw_rst_valid", resp_valid, 0);
      chk("rmw_rst_ready", req_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rmw_rst_hold_we", ram_we, 0);
         chk("rmw_rst_hold_valid", resp_valid, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_ready", req_ready, 1);
         chk("post_rst_we", ram_we, 0);
         chk("post_rst_valid", resp_valid, 0);
      end
      chk("rmw_rst_mem", mem[17'h40], 32'h1299_AABB);
      do_load("lw_after_rst", 3'b010, 32'h100, 5'd15, 32'h40, 32'h1299_AABB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit of the MEM stage; sits directly upstream of the data RAM.
- Takes one memory request at a time from EX/MEM and drives the RAM's word-wide read and write ports.
- For loads, returns the byte, halfword or word, sign- or zero-extended, to writeback.
- RAM has no byte enables, so SB/SH are done as read-modify-write. Pipeline is stalled via req_ready while busy.

Parameters:
- MEM_AW, 17: word-address width of the data RAM (RAM depth = 2**MEM_AW words).
- ADDR_W, 32: byte-address width of requests.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low byte/halfword is used for SB/SH.
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rd  out  5  destination register; 0 for stores and errors.
- resp_rdata  out  32  extended load data; 0 otherwise.
- resp_err  out  1  misaligned or illegal funct3.
- ram_ce  out  1  RAM chip enable; equals ram_re | ram_we.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  MEM_AW  word address = req_addr[MEM_AW+1:2].
- ram_wdata  out  32  word to write.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  MEM_AW  word address.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_re.

Behaviour:
- Reset: state = IDLE. All outputs are 0 except req_ready = 1. Request registers are cleared.
- Accept: when req_valid && req_ready at a clock edge, latch we/funct3/addr/wdata/rd. Call the acceptance cycle C0.
- States: IDLE, LD_REQ, LD_DATA, RMW_RD, RMW_MRG, ST_WR, RESP.
- Error check at accept:
  - Misaligned: halfword access with addr[0] = 1, or word access with addr[1:0] != 0.
  - Illegal funct3: loads 011/110/111; stores > 010.
  - On error: IDLE -> RESP with resp_err = 1, resp_rdata = 0, resp_rd = 0. No RAM access; ram_ce stays 0.
- Load:
  - C1 LD_REQ: ram_re = 1, ram_raddr = word address.
  - C2 LD_DATA: ram_rdata is sampled and lane-selected by addr[1:0] (byte) or addr[1] (halfword).
  - Extension: sign-extend for LB/LH, zero-extend for LBU/LHU, pass-through for LW.
  - C3 RESP: resp_valid = 1, resp_rd = latched rd. Back in IDLE at C4.
- SW:
  - C1 ST_WR: ram_we = 1, ram_wdata = req_wdata.
  - C2 RESP: resp_valid = 1, resp_rd = 0.
- SB/SH:
  - C1 RMW_RD: ram_re = 1.
  - C2 RMW_MRG: capture ram_rdata and replace only the addressed byte/halfword lane with req_wdata low bits.
  - C3 ST_WR: write the merged word.
  - C4 RESP.
- Signal rules:
  - ram_re and ram_we are never high in the same cycle.
  - ram_waddr/ram_raddr are 0 when the corresponding enable is low.
  - resp_valid is exactly one cycle per accepted request.
  - Writeback has no backpressure.
- req_ready is 0 in every non-IDLE state, including RESP. One request is outstanding at most; back-to-back requests are separated by their full latency.
- Load latency 3; SW 2; SB/SH 4; error 1 (cycles from C0 to RESP).
- Address upper bits above MEM_AW+1 are ignored; the word address wraps modulo RAM depth.
- Reset mid-operation: state goes to IDLE asynchronously and enables drop immediately.
  - An in-flight RMW never writes a partial word.
  - A load in flight produces no resp_valid.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Preload word 0x40 (byte addr 0x100) = 0x8899AABB. LB 0x101, rd = 5 -> C1 ram_re = 1, ram_raddr = 0x40; C3 resp_valid = 1, resp_rd = 5, resp_rdata = 0xFFFFFFAA.
- Same word. LHU 0x102 -> 0x00008899; LH 0x102 -> 0xFFFF8899; LW 0x100 -> 0x8899AABB, resp_err = 0.
- SB 0x103 wdata 0x00000012 -> C1 read, C3 ram_we = 1 with ram_wdata = 0x1299AABB, C4 resp_valid with resp_rd = 0. Then LW 0x100 -> 0x1299AABB.
- SW 0x200 wdata 0xDEADBEEF -> C1 ram_we = 1, ram_waddr = 0x80. Then LBU 0x203 -> 0x000000DE.
- LW 0x102 -> C1 resp_valid = 1, resp_err = 1, resp_rdata = 0; ram_ce stays 0 throughout. Same check for LH 0x101 and load funct3 = 011.
- SH 0x100 issued, rst pulsed during RMW_MRG -> ram_we never asserts and no resp_valid. req_ready = 1 after reset; memory word is unchanged.
